// File: rtl/px_pack_fifo_pkg.sv
// Shared types and helpers for the pixel packer.
// State enum, lanes-per-word derivation and strobe mask builder.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } pack_state_t;

  localparam int unsigned STRB_MAX = 64;

  function automatic int ppw_of(
    input int pix_w,
    input int word_w
  );
    return word_w / pix_w;
  endfunction

  function automatic logic [STRB_MAX-1:0] strb_for_lanes(
    input int unsigned n
  );
    logic [STRB_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < STRB_MAX; i++)
      m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/px_pack_fifo_if.sv
// Pixel stream in, packed word stream out.
// slave = packer side, master = driver/consumer side.
interface px_pack_fifo_if #(
  parameter int PIX_W  = 8,
  parameter int WORD_W = 32
);
  localparam int PPW = conv_pkg::ppw_of(PIX_W, WORD_W);

  logic              valid_in;
  logic [PIX_W-1:0]  px_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [PPW-1:0]    out_strb;
  logic              out_last;

  modport slave (
    input  valid_in,
    input  px_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_strb,
    output out_last
  );

  modport master (
    output valid_in,
    output px_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_strb,
    input  out_last
  );

endinterface

// File: rtl/px_pack_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A write while full is taken only when a read happens the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr)
        wptr <= wptr + 1'b1;
      if (do_rd)
        rptr <= rptr + 1'b1;
      if (do_wr && !do_rd)
        count <= count + 1'b1;
      else if (!do_wr && do_rd)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/px_pack_fifo.sv
// Packs a pixel stream into bus words behind a small FIFO.
// Define PX_PACK_STATS_EN to add word_count / drop_count outputs.
module px_pack_fifo
  import conv_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_PIX  = 614400
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  px_pack_fifo_if.slave bus,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow
`ifdef PX_PACK_STATS_EN
  ,
  output logic [31:0]   word_count,
  output logic [15:0]   drop_count
`endif
);
  localparam int PPW = ppw_of(PIX_W, WORD_W);
  localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int FW  = WORD_W + PPW + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  pack_state_t       state;
  pack_state_t       state_d;
  logic [31:0]       pcnt;
  logic [LW-1:0]     lane;
  logic [WORD_W-1:0] sh;
  logic [WORD_W-1:0] word;
  logic [PPW-1:0]    strb;
  logic              px_fire;
  logic              is_last;
  logic              push;
  logic              push_ok;
  logic              drop;
  logic              pop;
  logic              done_d;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [FW-1:0]     rd_data;

  assign px_fire = (state == RUN) && bus.valid_in;
  assign is_last = (pcnt == 32'(FRAME_PIX - 1));
  assign push    = px_fire &&
                   (is_last || lane == LW'(PPW - 1));
  assign pop     = !empty && bus.out_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;
  assign strb    = PPW'(strb_for_lanes(32'(lane) + 32'd1));
  assign busy    = (state != IDLE);

  // Lanes above the current one are already zero in sh.
  always_comb begin
    word = sh;
    word[lane*PIX_W +: PIX_W] = bus.px_in;
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    unique case (state)
      IDLE:
        if (start)
          state_d = RUN;
      RUN:
        if (px_fire && is_last)
          state_d = DRAIN;
      DRAIN:
        if (empty || (count == CW'(1) && pop)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      pcnt       <= '0;
      lane       <= '0;
      sh         <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= done_d;
      if (state == IDLE && start) begin
        pcnt     <= '0;
        lane     <= '0;
        sh       <= '0;
        overflow <= 1'b0;
      end else if (px_fire) begin
        pcnt <= pcnt + 32'd1;
        lane <= push ? '0 : lane + 1'b1;
        sh   <= push ? '0 : word;
        if (drop)
          overflow <= 1'b1;
      end
    end
  end

`ifdef PX_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn || (state == IDLE && start)) begin
      word_count <= '0;
      drop_count <= '0;
    end else begin
      if (pop)
        word_count <= word_count + 32'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push),
    .wr_data ({is_last, strb, word}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign {bus.out_last, bus.out_strb, bus.out_data} = rd_data;
  assign bus.out_valid = !empty;

endmodule

// File: doc/px_pack_fifo.md
# px_pack_fifo

Output stage directly downstream of `conv_top`. It accepts the convolution's one-pixel-per-cycle `valid_out`/`px_out` stream, with no backpressure available. It packs pixels little-endian into bus words and buffers them in a small FIFO. Words are presented on a valid/ready interface to the LiteX DMA writer, with a per-frame `last` marker, a done pulse, and overflow detection.

## Interface
- `PIX_W`, 8: pixel width; must equal `conv_top` `PIX_W`.
- `WORD_W`, 32: output word width; must be a multiple of `PIX_W`. `PPW = WORD_W/PIX_W` (4 by default).
- `FIFO_DEPTH`, 16: words; power of two, at least 4.
- `FRAME_PIX`, 614400: pixels per frame (640×960). Need not be a multiple of `PPW`.
- `clk`, in, 1: single clock for the whole block.
- `rstn`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: one-cycle pulse that arms a frame.
- `valid_in`, in, 1: pixel strobe from `conv_top` `valid_out`.
- `px_in`, in, `PIX_W`: pixel from `conv_top` `px_out`.
- `out_valid`, out, 1: word available.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, `WORD_W`: packed word; the first pixel sits in bits `[PIX_W-1:0]`.
- `out_strb`, out, `PPW`: lane enables; all ones except possibly on the final word.
- `out_last`, out, 1: marks the final word of the frame.
- `busy`, out, 1: high when the state is not IDLE.
- `frame_done`, out, 1: one-cycle completion pulse.
- `overflow`, out, 1: sticky flag; a word was dropped because the FIFO was full.

## Operation
- **IDLE.** `valid_in` is ignored. On `start`: clear the pixel counter, lane counter, shift register and `overflow`, then go to RUN.
- **RUN.** Each `valid_in` pixel is placed into lane `lane`, and `lane` increments. A push of {data, strb, last} into the FIFO happens when either:
  - `lane == PPW-1`, giving strb all ones; or
  - the pixel is the `FRAME_PIX`-th one, giving strb with the low `lane+1` bits set, unfilled lanes zero, and last=1.
- After a push, `lane` returns to 0. On the final pixel the state goes to DRAIN.
- **Push acceptance.** A push succeeds if the FIFO is not full, or if a pop (`out_valid && out_ready`) occurs in the same cycle.
  - If the push is refused, the word is dropped and `overflow` sets.
  - The pixel count still advances, so frame alignment is kept.
- **DRAIN.** `valid_in` is ignored. When the FIFO is empty, pulse `frame_done` for one cycle and go to IDLE.
  - A dropped last word therefore cannot hang the block.
- **`start` outside IDLE** is ignored.
- **Output handshake.** `out_valid` = FIFO not empty. `out_data`, `out_strb` and `out_last` are stable while `out_valid && !out_ready`. A pop happens on `out_valid && out_ready`.
- **Reset mid-frame.** Reset empties the FIFO, clears all counters and returns to IDLE. Partial words are discarded.

## Timing
- All outputs reset to 0, and the state resets to IDLE.
- Latency: when the word-completing pixel is sampled at edge N, `out_valid` is high after edge N if the FIFO was empty. The word therefore appears in the cycle following the pixel.
- Throughput: one word per cycle on the output, one pixel per cycle on the input.
- `frame_done` goes high in the cycle after the edge at which the FIFO becomes empty in DRAIN. It is high for exactly one cycle, and `busy` falls with it.
- `overflow` updates on the edge at which the refused push occurs.

## Configuration
- `PX_PACK_STATS_EN` defined adds two outputs:
  - `word_count`, 32 bits: words accepted by the consumer this frame.
  - `drop_count`, 16 bits: dropped words; saturates at 0xFFFF.
  - Both clear on `start` and reset.
- Without the macro, neither port nor its logic exists. All other behaviour is identical.

## Structure
- `conv_pkg` holds:
  - the state enum `pack_state_t` (IDLE, RUN, DRAIN);
  - the `PPW` derivation;
  - the function `strb_for_lanes(n)` returning the low-n-ones mask.
- Sub-module `sync_fifo`: show-ahead FIFO, width `WORD_W+PPW+1`, with `full`, `empty` and an occupancy count.

## Test plan
Use `FRAME_PIX=10` and `FIFO_DEPTH=4` unless noted.
- **Continuous 10-pixel frame**, pixels 0x01..0x0A, `out_ready`=1. Expect words 0x04030201 (strb F), 0x08070605 (strb F), 0x00000A09 (strb 3, last=1), then a single `frame_done` pulse one cycle after the last pop.
- **Throttled output**, `out_ready` low for 3 cycles mid-word. Expect `out_data`, `out_strb` and `out_last` held stable, no loss, and `overflow`=0.
- **Overflow**, `FRAME_PIX=40`, `out_ready`=0 throughout. Expect 4 words buffered, words 5..10 dropped, `overflow`=1. Raise `out_ready`: 4 words drain, then `frame_done`; no last word is seen.
- **Reset in RUN** after 6 pixels. Expect `out_valid`=0 and `busy`=0. A new `start` plus 10 pixels produces the exact sequence from the first test.
- **Start ignored and input ignored**: `start` pulsed during RUN has no effect, and `valid_in` in IDLE produces no output.
- **With `PX_PACK_STATS_EN`**: after the overflow test, expect `word_count`=4 and `drop_count`=6.
